// File: rtl/pcm_conv_codec.sv
// A-law 13-segment PCM compressor, MSB-first serializer and rate-1/2 K=3 convolutional encoder,
// plus an independent registered A-law expander for received codes.
module pcm_conv_codec #(
    parameter logic [2:0] G0 = 3'b111,
    parameter logic [2:0] G1 = 3'b101
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_en,
    input  logic       send,
    input  logic [7:0] in,
    input  logic [7:0] dec_code,
    output logic [7:0] pcm_code,
    output logic       ser_bit,
    output logic [1:0] conv_out,
    output logic       conv_valid,
    output logic       busy,
    output logic [7:0] dec_out
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Step for segment s is 1 << seg_shift(s); segments 0 and 1 both use step 1.
    function automatic logic [10:0] seg_start(input logic [2:0] s);
        case (s)
            3'd0:    seg_start = 11'd0;
            3'd1:    seg_start = 11'd16;
            3'd2:    seg_start = 11'd32;
            3'd3:    seg_start = 11'd64;
            3'd4:    seg_start = 11'd128;
            3'd5:    seg_start = 11'd256;
            3'd6:    seg_start = 11'd512;
            default: seg_start = 11'd1024;
        endcase
    endfunction

    function automatic logic [2:0] seg_shift(input logic [2:0] s);
        seg_shift = (s == 3'd0) ? 3'd0 : 3'(s - 3'd1);
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_cnt;
    logic        r_d1;
    logic        r_d2;
    logic [7:0]  r_pcm;
    logic        r_ser;
    logic [1:0]  r_conv;
    logic        r_valid;
    logic [7:0]  r_dec;

    logic [7:0]  w_neg;
    logic [6:0]  w_m8;
    logic [10:0] w_m;
    logic [2:0]  w_seg;
    logic [10:0] w_diff;
    logic [3:0]  w_lvl;
    logic [7:0]  w_code;

    logic        w_load;
    logic        w_enc;
    logic        w_bit;
    logic        w_sym1;
    logic        w_sym0;

    logic [2:0]  w_dshift;
    logic [10:0] w_dstep;
    logic [10:0] w_v;
    logic [7:0]  w_mag;
    logic [7:0]  w_dec;

    // Compressor: magnitude scaled to 11 bits, then segment search and level quantisation.
    always_comb begin
        w_neg = 8'(~in + 8'd1);
        if (in == 8'h80) begin
            w_m8 = 7'd127;
        end else if (in[7]) begin
            w_m8 = w_neg[6:0];
        end else begin
            w_m8 = in[6:0];
        end
        w_m = {w_m8, 4'b0000};
        if (w_m >= 11'd1024)     w_seg = 3'd7;
        else if (w_m >= 11'd512) w_seg = 3'd6;
        else if (w_m >= 11'd256) w_seg = 3'd5;
        else if (w_m >= 11'd128) w_seg = 3'd4;
        else if (w_m >= 11'd64)  w_seg = 3'd3;
        else if (w_m >= 11'd32)  w_seg = 3'd2;
        else if (w_m >= 11'd16)  w_seg = 3'd1;
        else                     w_seg = 3'd0;
        w_diff = w_m - seg_start(w_seg);
        w_lvl  = 4'(w_diff >> seg_shift(w_seg));
        w_code = {~in[7], w_seg, w_lvl};
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_enc        = 1'b0;
        w_bit        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bit_en && send) begin
                    w_load       = 1'b1;
                    w_enc        = 1'b1;
                    w_bit        = w_code[7];
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bit_en) begin
                    w_enc = 1'b1;
                    w_bit = r_shift[7];
                    if (r_cnt == 3'd7) begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        w_sym1 = ^(G0 & {w_bit, r_d1, r_d2});
        w_sym0 = ^(G1 & {w_bit, r_d1, r_d2});
    end

    // r_cnt wraps 7 -> 0 on the 8th bit, leaving it ready for the next load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_d1    <= 1'b0;
            r_d2    <= 1'b0;
            r_pcm   <= '0;
            r_ser   <= 1'b0;
            r_conv  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_valid <= w_enc;
            if (w_load) begin
                r_pcm   <= w_code;
                r_shift <= {w_code[6:0], 1'b0};
                r_cnt   <= 3'd1;
            end else if (w_enc) begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_cnt   <= r_cnt + 3'd1;
            end
            if (w_enc) begin
                r_d1   <= w_bit;
                r_d2   <= r_d1;
                r_ser  <= w_bit;
                r_conv <= {w_sym1, w_sym0};
            end
        end
    end

    // Expander: reconstruct at the middle of the quantisation step.
    always_comb begin
        w_dshift = seg_shift(dec_code[6:4]);
        w_dstep  = 11'(11'd1 << w_dshift);
        w_v      = seg_start(dec_code[6:4]) + 11'({7'b0, dec_code[3:0]} << w_dshift) + (w_dstep >> 1);
        w_mag    = 8'(w_v >> 4);
        w_dec    = dec_code[7] ? w_mag : 8'(~w_mag + 8'd1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dec <= '0;
        end else begin
            r_dec <= w_dec;
        end
    end

    assign pcm_code   = r_pcm;
    assign ser_bit    = r_ser;
    assign conv_out   = r_conv;
    assign conv_valid = r_valid;
    assign busy       = (r_state == S_BUSY);
    assign dec_out    = r_dec;

endmodule

// File: tb/tb_pcm_conv_codec.sv
// Directed bench for pcm_conv_codec: hand-computed codes, symbol streams and decoded samples.
module tb_pcm_conv_codec;

    logic       clk;
    logic       reset;
    logic       bit_en;
    logic       send;
    logic [7:0] in;
    logic [7:0] dec_code;
    logic [7:0] pcm_code;
    logic       ser_bit;
    logic [1:0] conv_out;
    logic       conv_valid;
    logic       busy;
    logic [7:0] dec_out;

    int checks = 0;
    int errors = 0;

    logic [1:0] d4_conv  [8] = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11};
    logic       d4_bits  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] e1_conv1 [8] = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 2'b11};
    logic [1:0] e1_conv2 [8] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 2'b11};
    logic [7:0] cmp_in   [5] = '{8'd35, 8'd104, 8'd0, 8'hEC, 8'h80};
    logic [7:0] cmp_exp  [5] = '{8'hE1, 8'hFA, 8'h80, 8'h54, 8'h7F};
    logic [7:0] dec_in   [5] = '{8'h80, 8'hD4, 8'hE1, 8'h54, 8'hFA};
    logic [7:0] dec_exp  [5] = '{8'h00, 8'd20, 8'd35, 8'hEC, 8'd106};

    pcm_conv_codec #(.G0(3'b111), .G1(3'b101)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_en     (bit_en),
        .send       (send),
        .in         (in),
        .dec_code   (dec_code),
        .pcm_code   (pcm_code),
        .ser_bit    (ser_bit),
        .conv_out   (conv_out),
        .conv_valid (conv_valid),
        .busy       (busy),
        .dec_out    (dec_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic strobe();
        @(negedge clk) bit_en = 1'b1;
        @(negedge clk) bit_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pcm"},   pcm_code, 8'h00);
        check({tag, "_ser"},   8'(ser_bit), 8'h00);
        check({tag, "_conv"},  8'(conv_out), 8'h00);
        check({tag, "_valid"}, 8'(conv_valid), 8'h00);
        check({tag, "_busy"},  8'(busy), 8'h00);
        check({tag, "_dec"},   dec_out, 8'h00);
    endtask

    initial begin
        logic [1:0] hold_conv;
        logic       hold_ser;
        int         gap;

        reset = 1'b0; bit_en = 1'b0; send = 1'b0; in = 8'h00; dec_code = 8'h00;
        #1;
        check_all_zero("reset_async");
        repeat (3) @(negedge clk);
        check_all_zero("reset_hold");
        reset = 1'b1;

        // send low: strobes and input changes must not start anything
        for (int i = 0; i < 4; i++) begin
            in = 8'($urandom);
            strobe();
            check("idle_busy",  8'(busy), 8'h00);
            check("idle_valid", 8'(conv_valid), 8'h00);
            check("idle_conv",  8'(conv_out), 8'h00);
        end

        // frame for in=20 with a bit_en gap after the 3rd symbol
        in = 8'd20; send = 1'b1;
        strobe();
        send = 1'b0;
        check("d4_pcm",  pcm_code, 8'hD4);
        check("d4_busy", 8'(busy), 8'h01);
        check("d4_valid", 8'(conv_valid), 8'h01);
        check("d4_ser0", 8'(ser_bit), 8'(d4_bits[0]));
        check("d4_conv0", 8'(conv_out), 8'(d4_conv[0]));
        for (int i = 1; i < 8; i++) begin
            if (i == 3) begin
                hold_conv = conv_out;
                hold_ser  = ser_bit;
                gap = int'($urandom_range(6, 2));
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check("gap_valid", 8'(conv_valid), 8'h00);
                    check("gap_conv",  8'(conv_out), 8'(hold_conv));
                    check("gap_ser",   8'(ser_bit), 8'(hold_ser));
                    check("gap_busy",  8'(busy), 8'h01);
                end
            end
            strobe();
            check("d4_ser",  8'(ser_bit), 8'(d4_bits[i]));
            check("d4_conv", 8'(conv_out), 8'(d4_conv[i]));
            check("d4_valid", 8'(conv_valid), 8'h01);
        end
        check("d4_busy_end", 8'(busy), 8'h00);
        @(negedge clk);
        check("d4_valid_drop", 8'(conv_valid), 8'h00);
        check("d4_conv_hold",  8'(conv_out), 8'(d4_conv[7]));

        // back-to-back frames of in=35; encoder memory carries into frame 2
        in = 8'd35; send = 1'b1;
        for (int i = 0; i < 16; i++) begin
            strobe();
            if (i == 8) send = 1'b0;
            if (i < 8) check("b2b_conv1", 8'(conv_out), 8'(e1_conv1[i]));
            else       check("b2b_conv2", 8'(conv_out), 8'(e1_conv2[i - 8]));
            check("b2b_valid", 8'(conv_valid), 8'h01);
            if (i == 7) check("b2b_busy_boundary", 8'(busy), 8'h00);
            if (i == 8) begin
                check("b2b_busy_reload", 8'(busy), 8'h01);
                check("b2b_pcm", pcm_code, 8'hE1);
            end
        end
        check("b2b_busy_end", 8'(busy), 8'h00);

        // compressor vectors via frame loads
        for (int k = 0; k < 5; k++) begin
            in = cmp_in[k]; send = 1'b1;
            strobe();
            send = 1'b0;
            check("cmp_pcm", pcm_code, cmp_exp[k]);
            check("cmp_ser", 8'(ser_bit), 8'({7'b0, cmp_exp[k][7]}));
            repeat (7) strobe();
            check("cmp_busy_end", 8'(busy), 8'h00);
        end

        // expander vectors, one clock latency
        for (int k = 0; k < 5; k++) begin
            @(negedge clk) dec_code = dec_in[k];
            @(negedge clk);
            check("dec_out", dec_out, dec_exp[k]);
        end

        // reset during the 4th symbol slot of a frame
        in = 8'd20; send = 1'b1;
        strobe();
        send = 1'b0;
        repeat (3) strobe();
        check("pre_reset_busy", 8'(busy), 8'h01);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        @(negedge clk) bit_en = 1'b1;
        @(negedge clk) bit_en = 1'b0;
        check_all_zero("reset_strobe");
        reset = 1'b1;
        in = 8'd20; send = 1'b1;
        strobe();
        send = 1'b0;
        check("fresh_pcm", pcm_code, 8'hD4);
        check("fresh_conv0", 8'(conv_out), 8'(d4_conv[0]));
        for (int i = 1; i < 8; i++) begin
            strobe();
            check("fresh_conv", 8'(conv_out), 8'(d4_conv[i]));
        end
        check("fresh_busy_end", 8'(busy), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcm_conv_codec.md
Name: pcm_conv_codec

Overview:
- Transmit-side source/channel coding core of the 2FSK link.
- Compresses an 8-bit signed sample into an 8-bit A-law 13-segment PCM code.
- Serializes the code MSB-first and runs each bit through a rate-1/2, K=3 convolutional encoder, producing 2-bit symbols for the two2one/modulator stage.
- Also contains an independent A-law PCM decoder that expands a received 8-bit code back to a signed sample.

Parameters:
G0, 3'b111, generator for conv_out[1]; taps {b, d1, d2}.
G1, 3'b101, generator for conv_out[0]; taps {b, d1, d2}.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset.
bit_en  input  1  one-clk-wide bit-rate strobe; the serializer and encoder advance only when it is high.
send  input  1  frame enable; sampled at frame boundaries.
in  input  8  two's-complement sample to encode.
dec_code  input  8  received PCM code to decode.
pcm_code  output  8  code of the frame currently being sent; latched at frame load.
ser_bit  output  1  PCM bit most recently fed to the encoder.
conv_out  output  2  convolutional symbol {c_g0, c_g1}.
conv_valid  output  1  high for one clk after each encoded bit.
busy  output  1  frame in progress.
dec_out  output  8  two's-complement decoded sample.

Behaviour:
Reset (reset=0, asynchronous):
- All outputs and all state go to 0: encoder memory d1=d2=0, bit counter=0, idle.
- Reset mid-frame aborts the frame; no partial symbols are emitted afterwards.

A-law compress (combinational, feeds the frame load):
- Polarity p = 1 if in >= 0, else 0.
- m8 = |in|; m8 saturates to 127 for in = -128.
- m = m8 << 4, giving an 11-bit value 0..2032.
- Segment starts 0, 16, 32, 64, 128, 256, 512, 1024 with steps 1, 1, 2, 4, 8, 16, 32, 64.
- seg = index of the highest start <= m.
- lvl = (m - start) / step, truncated, 4 bits.
- Code = {p, seg[2:0], lvl[3:0]}.

Serializer / convolutional encoder (on a clk edge with bit_en=1):
- Idle and send=1: load the compressed code into the shift register and pcm_code, encode bit7 in the same edge, set busy=1, counter=1.
- Busy: encode the next bit MSB-first. After the 8th bit, set busy=0.
- A new frame can load on the very next bit_en if send is still 1, giving back-to-back frames with no gap.
- Idle and send=0: nothing changes; encoder memory is held.
- Per encoded bit b:
  - conv_out[1] = b ^ d1 ^ d2 (per G0).
  - conv_out[0] = b ^ d2 (per G1).
  - Then d2 <= d1, d1 <= b.
  - ser_bit <= b; conv_valid <= 1.
- conv_valid is 0 on every other clk.
- conv_out and ser_bit hold their values between strobes.
- Encoder memory persists across frames. No tail/flush bits are inserted.
- bit_en=0 freezes all serializer and encoder state.
- send changing mid-frame has no effect until the frame boundary.

A-law expand (registered, 1-clk latency, independent of bit_en):
- From dec_code: seg = dec_code[6:4], lvl = dec_code[3:0].
- v = start[seg] + lvl*step[seg] + (step[seg] >> 1).
- mag = v >> 4.
- dec_out = dec_code[7] ? mag : -mag (two's complement).
- A code of 0x00 or 0x80 decodes to 0.

Test Plan:
- Reset then in=8'd20, send=1, one bit_en → pcm_code=0xD4, busy=1. Over 8 strobes ser_bit = 1,1,0,1,0,1,0,0 and conv_out = 11,01,01,00,10,00,10,11; busy=0 after the 8th strobe when send is low.
- Compress checks: in=35 → 0xE1; in=104 → 0xFA; in=0 → 0x80; in=-20 → 0x54; in=-128 → 0x7F.
- Decode checks (1 clk latency): dec_code 0xD4 → 20; 0xE1 → 35; 0xFA → 106; 0x54 → -20 (0xEC); 0x80 → 0.
- send held at 1 for 16 strobes → second frame loads on strobe 9 with no gap, and encoder memory continues (first symbol of the second frame depends on the last two bits of the first frame). bit_en gaps of random length → outputs unchanged during gaps.
- Assert reset at strobe 4 of a frame → all outputs 0 immediately (asynchronously). After release with send=1, a fresh frame starts from d1=d2=0.
- send=0 throughout → busy, conv_valid and conv_out remain 0 regardless of bit_en and in.
